// File: rtl/masked_serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial masked subtractor.
package masked_serial_subtractor_pkg;

  // Control sequence: one LOAD cycle, then two cycles per bit (gadget latency 1).
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    STEP0 = 3'd2,
    STEP1 = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Fresh random bits one HPC2 AND gadget needs for nshares shares.
  function automatic int and_nrnd(input int nshares);
    return nshares * (nshares - 1) / 2;
  endfunction

  // Bit position of the random bit shared by share pair (i, j), order-independent.
  function automatic int pair_idx(input int i, input int j, input int nshares);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * nshares - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

endpackage

// File: rtl/masked_serial_subtractor_borrow_step.sv
// One masked borrow-propagation step plus the HPC2 AND gadget it is built on.
module MSKand_HPC2
  import masked_serial_subtractor_pkg::*;
#(
  parameter int d = 2
) (
  input  logic                      i_clk,
  input  logic [d-1:0]              i_a,
  input  logic [d-1:0]              i_b,
  input  logic [and_nrnd(d)-1:0]    i_rnd,
  output logic [d-1:0]              o_c
);

  for (genvar i = 0; i < d; i++) begin : g_share
    logic         r_ab;
    logic         r_ai;
    logic [d-1:0] w_cross;

    // Stage boundary: diagonal product and a_i captured alongside the cross terms.
    always_ff @(posedge i_clk) begin
      r_ab <= i_a[i] & i_b[i];
      r_ai <= i_a[i];
    end

    for (genvar j = 0; j < d; j++) begin : g_pair
      if (j == i) begin : g_diag
        assign w_cross[j] = 1'b0;
      end else begin : g_off
        localparam int P = pair_idx(i, j, d);
        logic r_u;
        logic r_v;

        // Stage boundary: refreshed cross terms, randomness cancels pairwise on recombination.
        always_ff @(posedge i_clk) begin
          r_u <= ~i_a[i] & i_rnd[P];
          r_v <= i_b[j] ^ i_rnd[P];
        end

        assign w_cross[j] = r_u ^ (r_ai & r_v);
      end
    end

    assign o_c[i] = r_ab ^ (^w_cross);
  end

endmodule

module masked_borrow_step
  import masked_serial_subtractor_pkg::*;
#(
  parameter int d = 2
) (
  input  logic                        i_clk,
  input  logic [d-1:0]                i_a,
  input  logic [d-1:0]                i_b,
  input  logic [d-1:0]                i_br,
  input  logic [2*and_nrnd(d)-1:0]    i_rnd,
  output logic [d-1:0]                o_diff,
  output logic [d-1:0]                o_br
);

  localparam int NR = and_nrnd(d);
  // Masked inversion flips share 0 only.
  localparam logic [d-1:0] INV_MASK = {{(d-1){1'b0}}, 1'b1};

  logic [d-1:0] w_x;
  logic [d-1:0] w_na;
  logic [d-1:0] w_nx;
  logic [d-1:0] w_t1;
  logic [d-1:0] w_t2;

  assign w_x    = i_a ^ i_b;
  assign w_na   = i_a ^ INV_MASK;
  assign w_nx   = w_x ^ INV_MASK;
  assign o_diff = w_x ^ i_br;

  // ~a & b : borrow generated at this bit.
  MSKand_HPC2 #(.d(d)) u_and_gen (
    .i_clk (i_clk),
    .i_a   (w_na),
    .i_b   (i_b),
    .i_rnd (i_rnd[0 +: NR]),
    .o_c   (w_t1)
  );

  // ~(a ^ b) & br : incoming borrow propagated through an equal bit pair.
  MSKand_HPC2 #(.d(d)) u_and_prop (
    .i_clk (i_clk),
    .i_a   (w_nx),
    .i_b   (i_br),
    .i_rnd (i_rnd[NR +: NR]),
    .o_c   (w_t2)
  );

  // The two borrow terms can never both be 1, so a share-wise XOR acts as OR.
  assign o_br = w_t1 ^ w_t2;

endmodule

// File: rtl/masked_serial_subtractor.sv
// Bit-serial masked W-bit subtractor: LSB-first borrow chain, masked a-b and borrow-out.
module masked_serial_subtractor
  import masked_serial_subtractor_pkg::*;
#(
  parameter int d = 2,
  parameter int W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [W*d-1:0]       in_a,
  input  logic [W*d-1:0]       in_b,
  input  logic [d*(d-1)-1:0]   rnd,
  output logic                 busy,
  output logic                 done,
  output logic [W*d-1:0]       out_diff,
  output logic [d-1:0]         out_borrow
);

  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [W*d-1:0]   r_a;
  logic [W*d-1:0]   r_b;
  logic [d-1:0]     r_br;
  logic [W*d-1:0]   r_diff;
  logic [d-1:0]     r_borrow;
  logic [d-1:0]     w_diff_bit;
  logic [d-1:0]     w_br_nxt;
  logic             w_last;

  assign w_last = (r_cnt == LAST_BIT);

  masked_borrow_step #(.d(d)) u_step (
    .i_clk  (clk),
    .i_a    (r_a[d-1:0]),
    .i_b    (r_b[d-1:0]),
    .i_br   (r_br),
    .i_rnd  (rnd),
    .o_diff (w_diff_bit),
    .o_br   (w_br_nxt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = LOAD;
      LOAD:    w_state_nxt = STEP0;
      STEP0:   w_state_nxt = STEP1;
      STEP1:   w_state_nxt = w_last ? DONE : STEP0;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Counter, borrow chain and result registers; reset discards any partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_br     <= '0;
      r_diff   <= '0;
      r_borrow <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cnt <= '0;
            r_br  <= '0;
          end
        end
        STEP1: begin
          r_diff <= {w_diff_bit, r_diff[W*d-1:d]};
          r_br   <= w_br_nxt;
          if (w_last) r_borrow <= w_br_nxt;
          else        r_cnt    <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Operand shift registers: loaded on accept, shifted one share group per finished bit.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && start) begin
      r_a <= in_a;
      r_b <= in_b;
    end else if (r_state == STEP1) begin
      r_a <= {{d{1'b0}}, r_a[W*d-1:d]};
      r_b <= {{d{1'b0}}, r_b[W*d-1:d]};
    end
  end

  assign busy       = (r_state == LOAD) || (r_state == STEP0) || (r_state == STEP1);
  assign done       = (r_state == DONE);
  assign out_diff   = r_diff;
  assign out_borrow = r_borrow;

endmodule

// File: tb/tb_masked_serial_subtractor.sv
`timescale 1ns/1ps
// Bench for masked_serial_subtractor: d=2/W=8 and d=3/W=16 instances against a plain-arithmetic model.
module tb_masked_serial_subtractor;

  localparam int D0 = 2;
  localparam int W0 = 8;
  localparam int D1 = 3;
  localparam int W1 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_v [2];
  logic [47:0] a_v     [2];
  logic [47:0] b_v     [2];
  logic [5:0]  rnd_v   [2];

  logic        busy0, done0, busy1, done1;
  logic [15:0] diff0;
  logic [1:0]  bor0;
  logic [47:0] diff1;
  logic [2:0]  bor1;

  logic        o_busy [2];
  logic        o_done [2];
  logic [47:0] o_diff [2];
  logic [2:0]  o_bor  [2];

  assign o_busy[0] = busy0;
  assign o_busy[1] = busy1;
  assign o_done[0] = done0;
  assign o_done[1] = done1;
  assign o_diff[0] = {32'd0, diff0};
  assign o_diff[1] = diff1;
  assign o_bor[0]  = {1'b0, bor0};
  assign o_bor[1]  = bor1;

  masked_serial_subtractor #(.d(D0), .W(W0)) u_dut0 (
    .clk        (clk),
    .rst        (rst),
    .start      (start_v[0]),
    .in_a       (a_v[0][15:0]),
    .in_b       (b_v[0][15:0]),
    .rnd        (rnd_v[0][1:0]),
    .busy       (busy0),
    .done       (done0),
    .out_diff   (diff0),
    .out_borrow (bor0)
  );

  masked_serial_subtractor #(.d(D1), .W(W1)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .start      (start_v[1]),
    .in_a       (a_v[1]),
    .in_b       (b_v[1]),
    .rnd        (rnd_v[1]),
    .busy       (busy1),
    .done       (done1),
    .out_diff   (diff1),
    .out_borrow (bor1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  function automatic int nd(input int k);
    return (k == 0) ? D0 : D1;
  endfunction

  function automatic int nw(input int k);
    return (k == 0) ? W0 : W1;
  endfunction

  function automatic logic [15:0] wmask(input int k);
    return (k == 0) ? 16'h00FF : 16'hFFFF;
  endfunction

  function automatic logic [15:0] unmask(input logic [47:0] v, input int k);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < nw(k); i++)
      for (int s = 0; s < nd(k); s++)
        r[i] = r[i] ^ v[i*nd(k)+s];
    return r;
  endfunction

  // Split each bit into shares: shares 1.. come from r, share 0 makes the XOR equal the bit.
  function automatic logic [47:0] share(input logic [15:0] val, input logic [47:0] r, input int k);
    logic [47:0] v;
    logic        acc;
    v = '0;
    for (int i = 0; i < nw(k); i++) begin
      acc = val[i];
      for (int s = 1; s < nd(k); s++) begin
        v[i*nd(k)+s] = r[i*nd(k)+s];
        acc = acc ^ r[i*nd(k)+s];
      end
      v[i*nd(k)] = acc;
    end
    return v;
  endfunction

  function automatic logic [47:0] rand48();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[47:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_cnt = cycles since an accepted start (0 = idle); results land after 2W+2 cycles.
  int          m_cnt   [2];
  bit          m_zero  [2];
  bit          m_valid [2];
  logic [15:0] m_pd    [2];
  logic [15:0] m_rd    [2];
  logic        m_pb    [2];
  logic        m_rb    [2];
  logic [15:0] ua      [2];
  logic [15:0] ub      [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_cnt[k]   = 0;
        m_zero[k]  = 1'b1;
        m_valid[k] = 1'b0;
      end else if (m_cnt[k] == 0) begin
        if (start_v[k]) begin
          m_cnt[k] = 1;
          m_pd[k]  = (ua[k] - ub[k]) & wmask(k);
          m_pb[k]  = (ua[k] < ub[k]);
        end
      end else if (m_cnt[k] == 2*nw(k)+2) begin
        m_cnt[k] = 0;
      end else begin
        m_cnt[k] = m_cnt[k] + 1;
        if (m_cnt[k] == 2*nw(k)+2) begin
          m_rd[k]    = m_pd[k];
          m_rb[k]    = m_pb[k];
          m_valid[k] = 1'b1;
          m_zero[k]  = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check((k == 0) ? "busy_w8" : "busy_w16", o_busy[k],
              (m_cnt[k] >= 1) && (m_cnt[k] <= 2*nw(k)+1));
        check((k == 0) ? "done_w8" : "done_w16", o_done[k], m_cnt[k] == 2*nw(k)+2);
        if (m_cnt[k] == 0 || m_cnt[k] == 2*nw(k)+2) begin
          if (m_zero[k]) begin
            check((k == 0) ? "zero_diff_w8" : "zero_diff_w16", o_diff[k], 64'd0);
            check((k == 0) ? "zero_bor_w8" : "zero_bor_w16", o_bor[k], 64'd0);
          end else if (m_valid[k]) begin
            check((k == 0) ? "diff_w8" : "diff_w16", unmask(o_diff[k], k), m_rd[k]);
            check((k == 0) ? "borrow_w8" : "borrow_w16", ^o_bor[k], m_rb[k]);
          end
        end
      end
    end
  end

  // Fresh randomness every cycle.
  initial begin
    rnd_v[0] = '0;
    rnd_v[1] = '0;
    forever begin
      @(negedge clk);
      rnd_v[0] = 6'($urandom());
      rnd_v[1] = 6'($urandom());
    end
  end

  // Accept a start at cycle t; returns at the negedge inside cycle t+1.
  task automatic start_run(input int k, input logic [15:0] a, input logic [15:0] b,
                           input logic [47:0] ra, input logic [47:0] rb);
    @(negedge clk);
    ua[k]      = a;
    ub[k]      = b;
    a_v[k]     = share(a, ra, k);
    b_v[k]     = share(b, rb, k);
    start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
  endtask

  // Bounded wait for done; latency counted in cycles after the accepting cycle.
  task automatic wait_done(input int k, input string name);
    int lat;
    lat = -1;
    for (int n = 1; n <= 2*nw(k)+10; n++) begin
      if (o_done[k]) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
    check({name, "_latency"}, lat, 2*nw(k)+2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of run, expected completion within time limit");
    $fatal(1, "watchdog");
  end

  logic [47:0] raw1;
  logic [15:0] ta, tb, texp;
  int          ndone;

  initial begin
    rst        = 1'b1;
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    a_v[0] = '0; a_v[1] = '0;
    b_v[0] = '0; b_v[1] = '0;
    ua[0]  = '0; ua[1]  = '0;
    ub[0]  = '0; ub[1]  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy0", busy0, 0);
    check("rst_done0", done0, 0);
    check("rst_diff0", diff0, 0);
    check("rst_bor0",  bor0,  0);
    check("rst_busy1", busy1, 0);
    check("rst_done1", done1, 0);
    check("rst_diff1", diff1, 0);
    check("rst_bor1",  bor1,  0);
    chk_en = 1'b1;
    rst    = 1'b0;

    // 1: small positive difference
    start_run(0, 16'h05, 16'h03, rand48(), rand48());
    wait_done(0, "t1");
    check("t1_diff", unmask(o_diff[0], 0), 16'h02);
    check("t1_borrow", ^o_bor[0], 0);

    // 2: negative difference and full borrow chain
    start_run(0, 16'h03, 16'h05, rand48(), rand48());
    wait_done(0, "t2a");
    check("t2a_diff", unmask(o_diff[0], 0), 16'hFE);
    check("t2a_borrow", ^o_bor[0], 1);
    start_run(0, 16'h00, 16'hFF, rand48(), rand48());
    wait_done(0, "t2b");
    check("t2b_diff", unmask(o_diff[0], 0), 16'h01);
    check("t2b_borrow", ^o_bor[0], 1);

    // 3: equal operands under two different share splits
    start_run(0, 16'hA5, 16'hA5, 48'h0, 48'h0);
    wait_done(0, "t3a");
    check("t3a_diff", unmask(o_diff[0], 0), 16'h00);
    check("t3a_borrow", ^o_bor[0], 0);
    raw1 = o_diff[0];
    start_run(0, 16'hA5, 16'hA5, 48'hFFFF_FFFF_FFFF, 48'h0);
    wait_done(0, "t3b");
    check("t3b_diff", unmask(o_diff[0], 0), 16'h00);
    check("t3b_borrow", ^o_bor[0], 0);
    check("t3_shares_differ", raw1 != o_diff[0], 1);

    // 4: start pulses while busy and during DONE are ignored
    start_run(0, 16'h3C, 16'h5A, rand48(), rand48());
    ndone = 0;
    for (int n = 1; n <= 2*W0+8; n++) begin
      if (o_done[0]) begin
        ndone++;
        check("t4_done_cycle", n, 2*W0+2);
      end
      start_v[0] = (n == 3) || (n == 2*W0+2);
      if (n == 3) a_v[0] = share(16'h00FF, rand48(), 0);
      @(negedge clk);
    end
    check("t4_done_count", ndone, 1);
    check("t4_diff", unmask(o_diff[0], 0), 16'hE2);
    check("t4_borrow", ^o_bor[0], 1);

    // 5: reset in the middle of a run, then a clean run
    start_run(0, 16'h12, 16'h34, rand48(), rand48());
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_busy", busy0, 0);
    check("t5_done", done0, 0);
    check("t5_diff", diff0, 0);
    check("t5_bor",  bor0,  0);
    start_run(0, 16'h80, 16'h01, rand48(), rand48());
    wait_done(0, "t5");
    check("t5_res_diff", unmask(o_diff[0], 0), 16'h7F);
    check("t5_res_borrow", ^o_bor[0], 0);

    // 6: d=3, W=16, edge pairs then random pairs
    for (int r = 0; r < 203; r++) begin
      case (r)
        0:       begin ta = 16'hFFFF; tb = 16'h0000; end
        1:       begin ta = 16'h0000; tb = 16'h0001; end
        2:       begin ta = 16'h8000; tb = 16'h8000; end
        default: begin ta = 16'($urandom()); tb = 16'($urandom()); end
      endcase
      texp = ta - tb;
      start_run(1, ta, tb, rand48(), rand48());
      wait_done(1, "t6");
      check("t6_diff", unmask(o_diff[1], 1), texp);
      check("t6_borrow", ^o_bor[1], ta < tb);
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
